// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-reconfigurable raster timing generator.
// Produces hs/vs/de, active-area coordinates and sof/eol strobes from a
// pixel/line counter pair. New timing is captured into a shadow register set
// and swapped into the live set only at the last pixel of a frame.
// Optional feature: define VTG_PATTERN_EN to add a 24-bit colour-bar output
// 'rgb' aligned with de. Without the macro there is no rgb port and no
// pattern logic.
module video_timing_gen #(
    parameter int W        = 12,
    parameter int DEF_HA   = 640,
    parameter int DEF_HFP  = 16,
    parameter int DEF_HS   = 96,
    parameter int DEF_HBP  = 48,
    parameter int DEF_VA   = 480,
    parameter int DEF_VFP  = 10,
    parameter int DEF_VS   = 2,
    parameter int DEF_VBP  = 33,
    parameter bit DEF_HPOL = 1'b0,
    parameter bit DEF_VPOL = 1'b0
`ifdef VTG_PATTERN_EN
    ,
    parameter int BAR_SH   = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] cfg_ha,
    input  logic [W-1:0] cfg_hfp,
    input  logic [W-1:0] cfg_hs,
    input  logic [W-1:0] cfg_hbp,
    input  logic [W-1:0] cfg_va,
    input  logic [W-1:0] cfg_vfp,
    input  logic [W-1:0] cfg_vs,
    input  logic [W-1:0] cfg_vbp,
    input  logic         cfg_hpol,
    input  logic         cfg_vpol,
    input  logic         cfg_load,
    output logic         cfg_busy,
    output logic         hs,
    output logic         vs,
    output logic         de,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         sof,
    output logic         eol
`ifdef VTG_PATTERN_EN
    ,
    output logic [23:0]  rgb
`endif
);

    typedef struct packed {
        logic [W-1:0] ha;
        logic [W-1:0] hfp;
        logic [W-1:0] hs;
        logic [W-1:0] hbp;
        logic [W-1:0] va;
        logic [W-1:0] vfp;
        logic [W-1:0] vs;
        logic [W-1:0] vbp;
        logic         hpol;
        logic         vpol;
    } timing_t;

    localparam timing_t DEF_T = '{
        ha:   W'(DEF_HA),  hfp: W'(DEF_HFP), hs: W'(DEF_HS), hbp: W'(DEF_HBP),
        va:   W'(DEF_VA),  vfp: W'(DEF_VFP), vs: W'(DEF_VS), vbp: W'(DEF_VBP),
        hpol: DEF_HPOL,    vpol: DEF_VPOL
    };

    localparam logic [W+1:0] ONE_X = (W+2)'(1);
    localparam logic [W-1:0] ONE_W = W'(1);
    localparam logic [W+1:0] MAX_X = {2'b00, {W{1'b1}}};

    // Zero-length regions are not allowed, so a zero field becomes 1.
    function automatic logic [W-1:0] nonZero(input logic [W-1:0] v);
        return (v == '0) ? ONE_W : v;
    endfunction

    // Widen a field so region sums cannot wrap.
    function automatic logic [W+1:0] ext(input logic [W-1:0] v);
        return {2'b00, v};
    endfunction

    timing_t      liveQ, liveD, shadowQ, shadowD, capT;
    logic         busyQ, busyD;
    logic [W-1:0] hcQ, hcD, vcQ, vcD;
    logic         hsQ, hsD, vsQ, vsD, deQ, deD, sofQ, sofD, eolQ, eolD;
    logic [W-1:0] xQ, xD, yQ, yD;

    logic [W+1:0] capHt, capVt, liveHt, liveVt, hcX, vcX;
    logic [W+1:0] hsStart, hsStop, vsStart, vsStop;
    logic         capOk, lineEnd, frameEnd, inActive, inHsync, inVsync;
    logic         atSof, atEol;

    // Sanitise the incoming configuration before it can reach the shadow set.
    always_comb begin
        capT      = DEF_T;
        capT.ha   = nonZero(cfg_ha);
        capT.hfp  = nonZero(cfg_hfp);
        capT.hs   = nonZero(cfg_hs);
        capT.hbp  = nonZero(cfg_hbp);
        capT.va   = nonZero(cfg_va);
        capT.vfp  = nonZero(cfg_vfp);
        capT.vs   = nonZero(cfg_vs);
        capT.vbp  = nonZero(cfg_vbp);
        capT.hpol = cfg_hpol;
        capT.vpol = cfg_vpol;
    end

    assign capHt  = ext(capT.ha) + ext(capT.hfp) + ext(capT.hs) + ext(capT.hbp);
    assign capVt  = ext(capT.va) + ext(capT.vfp) + ext(capT.vs) + ext(capT.vbp);
    assign capOk  = (capHt <= MAX_X) && (capVt <= MAX_X);

    assign liveHt = ext(liveQ.ha) + ext(liveQ.hfp) + ext(liveQ.hs) + ext(liveQ.hbp);
    assign liveVt = ext(liveQ.va) + ext(liveQ.vfp) + ext(liveQ.vs) + ext(liveQ.vbp);

    assign hcX      = ext(hcQ);
    assign vcX      = ext(vcQ);
    assign lineEnd  = (hcX == liveHt - ONE_X);
    assign frameEnd = lineEnd && (vcX == liveVt - ONE_X);

    assign hsStart  = ext(liveQ.ha) + ext(liveQ.hfp);
    assign hsStop   = hsStart + ext(liveQ.hs);
    assign vsStart  = ext(liveQ.va) + ext(liveQ.vfp);
    assign vsStop   = vsStart + ext(liveQ.vs);

    assign inActive = (hcX < ext(liveQ.ha)) && (vcX < ext(liveQ.va));
    assign inHsync  = (hcX >= hsStart) && (hcX < hsStop);
    assign inVsync  = (vcX >= vsStart) && (vcX < vsStop);
    assign atSof    = (hcQ == '0) && (vcQ == '0);
    assign atEol    = (hcX == ext(liveQ.ha) - ONE_X) && (vcX < ext(liveQ.va));

    // Advance the raster, decode outputs and handle shadow capture/apply.
    always_comb begin
        hcD     = hcQ;
        vcD     = vcQ;
        liveD   = liveQ;
        shadowD = shadowQ;
        busyD   = busyQ;
        hsD     = hsQ;
        vsD     = vsQ;
        deD     = deQ;
        xD      = xQ;
        yD      = yQ;
        sofD    = sofQ;
        eolD    = eolQ;
        if (en) begin
            deD  = inActive;
            xD   = inActive ? hcQ : '0;
            yD   = inActive ? vcQ : '0;
            hsD  = inHsync ? liveQ.hpol : ~liveQ.hpol;
            vsD  = inVsync ? liveQ.vpol : ~liveQ.vpol;
            sofD = atSof;
            eolD = atEol;
            if (lineEnd) begin
                hcD = '0;
                vcD = frameEnd ? '0 : vcQ + ONE_W;
            end else begin
                hcD = hcQ + ONE_W;
            end
            if (busyQ && frameEnd) begin
                liveD = shadowQ;
                busyD = 1'b0;
            end
        end
        if (cfg_load && capOk) begin
            shadowD = capT;
            busyD   = 1'b1;
        end
    end

    // Raster state, timing sets and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcQ     <= '0;
            vcQ     <= '0;
            liveQ   <= DEF_T;
            shadowQ <= DEF_T;
            busyQ   <= 1'b0;
            hsQ     <= ~DEF_T.hpol;
            vsQ     <= ~DEF_T.vpol;
            deQ     <= 1'b0;
            xQ      <= '0;
            yQ      <= '0;
            sofQ    <= 1'b0;
            eolQ    <= 1'b0;
        end else begin
            hcQ     <= hcD;
            vcQ     <= vcD;
            liveQ   <= liveD;
            shadowQ <= shadowD;
            busyQ   <= busyD;
            hsQ     <= hsD;
            vsQ     <= vsD;
            deQ     <= deD;
            xQ      <= xD;
            yQ      <= yD;
            sofQ    <= sofD;
            eolQ    <= eolD;
        end
    end

    assign cfg_busy = busyQ;
    assign hs       = hsQ;
    assign vs       = vsQ;
    assign de       = deQ;
    assign x        = xQ;
    assign y        = yQ;
    assign sof      = sofQ;
    assign eol      = eolQ;

`ifdef VTG_PATTERN_EN
    logic [23:0] rgbQ, rgbD;
    logic [2:0]  bar;

    assign bar = hcQ[BAR_SH+2:BAR_SH];

    // Colour bars derived from the current pixel, same latency as de.
    always_comb begin
        rgbD = rgbQ;
        if (en) begin
            rgbD = inActive ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : 24'h0;
        end
    end

    // Pattern output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgbQ <= '0;
        end else begin
            rgbQ <= rgbD;
        end
    end

    assign rgb = rgbQ;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: a standard-timing instance checked against
// hand-computed line figures, and a small-timing instance checked every cycle
// against a linear-position raster model under directed and random stimulus.
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int W = 12;
    localparam int DEFS [0:7] = '{20, 3, 4, 5, 6, 2, 2, 3};

    logic         clk, rst, en;
    logic [W-1:0] cfgHa, cfgHfp, cfgHs, cfgHbp, cfgVa, cfgVfp, cfgVs, cfgVbp;
    logic         cfgHpol, cfgVpol, cfgLoad;
    logic [W-1:0] zeroW;
    logic         zeroBit, oneBit;

    logic         busyM, hsM, vsM, deM, sofM, eolM;
    logic [W-1:0] xM, yM;
    logic         busyDef, hsDef, vsDef, deDef, sofDef, eolDef;
    logic [W-1:0] xDef, yDef;
`ifdef VTG_PATTERN_EN
    logic [23:0]  rgbM, rgbDef;
`endif

    assign zeroW   = '0;
    assign zeroBit = 1'b0;
    assign oneBit  = 1'b1;

    int checkCount = 0;
    int passCount  = 0;
    bit checkOn    = 1'b0;

    video_timing_gen #(
        .DEF_HA(DEFS[0]), .DEF_HFP(DEFS[1]), .DEF_HS(DEFS[2]), .DEF_HBP(DEFS[3]),
        .DEF_VA(DEFS[4]), .DEF_VFP(DEFS[5]), .DEF_VS(DEFS[6]), .DEF_VBP(DEFS[7]),
        .DEF_HPOL(1'b0),  .DEF_VPOL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_ha(cfgHa), .cfg_hfp(cfgHfp), .cfg_hs(cfgHs), .cfg_hbp(cfgHbp),
        .cfg_va(cfgVa), .cfg_vfp(cfgVfp), .cfg_vs(cfgVs), .cfg_vbp(cfgVbp),
        .cfg_hpol(cfgHpol), .cfg_vpol(cfgVpol), .cfg_load(cfgLoad),
        .cfg_busy(busyM), .hs(hsM), .vs(vsM), .de(deM), .x(xM), .y(yM),
        .sof(sofM), .eol(eolM)
`ifdef VTG_PATTERN_EN
        , .rgb(rgbM)
`endif
    );

    video_timing_gen dutDef (
        .clk(clk), .rst(rst), .en(oneBit),
        .cfg_ha(zeroW), .cfg_hfp(zeroW), .cfg_hs(zeroW), .cfg_hbp(zeroW),
        .cfg_va(zeroW), .cfg_vfp(zeroW), .cfg_vs(zeroW), .cfg_vbp(zeroW),
        .cfg_hpol(zeroBit), .cfg_vpol(zeroBit), .cfg_load(zeroBit),
        .cfg_busy(busyDef), .hs(hsDef), .vs(vsDef), .de(deDef), .x(xDef), .y(yDef),
        .sof(sofDef), .eol(eolDef)
`ifdef VTG_PATTERN_EN
        , .rgb(rgbDef)
`endif
    );

    // Free-running pixel clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int mCfg [0:7];
    int sCfg [0:7];
    bit mHpol, mVpol, sHpol, sVpol, mBusy;
    int mHc, mVc;
    bit eHs, eVs, eDe, eSof, eEol;
    int eX, eY, eRgb;

    function automatic int lineLen();
        return mCfg[0] + mCfg[1] + mCfg[2] + mCfg[3];
    endfunction

    function automatic int frameLines();
        return mCfg[4] + mCfg[5] + mCfg[6] + mCfg[7];
    endfunction

    function automatic int framePos();
        return mVc * lineLen() + mHc;
    endfunction

    function automatic int nextPos();
        return (framePos() + 1) % (lineLen() * frameLines());
    endfunction

    function automatic int fixZero(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit capOk();
        return (fixZero(int'(cfgHa)) + fixZero(int'(cfgHfp)) + fixZero(int'(cfgHs)) +
                fixZero(int'(cfgHbp)) < 4096) &&
               (fixZero(int'(cfgVa)) + fixZero(int'(cfgVfp)) + fixZero(int'(cfgVs)) +
                fixZero(int'(cfgVbp)) < 4096);
    endfunction

    function automatic bit inWindow(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

    function automatic bit modelActive();
        return (mHc < mCfg[0]) && (mVc < mCfg[4]);
    endfunction

    function automatic int barColour(input int px);
        int b;
        b = (px >> 4) % 8;
        return (((b & 4) != 0) ? 32'hFF0000 : 0) | (((b & 2) != 0) ? 32'h00FF00 : 0) |
               (((b & 1) != 0) ? 32'h0000FF : 0);
    endfunction

    // Model: one pixel per enabled clock, position tracked as a linear frame offset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mHc <= 0; mVc <= 0; mBusy <= 1'b0;
            mHpol <= 1'b0; mVpol <= 1'b0; sHpol <= 1'b0; sVpol <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mCfg[i] <= DEFS[i];
                sCfg[i] <= DEFS[i];
            end
            eHs <= 1'b1; eVs <= 1'b1; eDe <= 1'b0; eSof <= 1'b0; eEol <= 1'b0;
            eX <= 0; eY <= 0; eRgb <= 0;
        end else begin
            if (en) begin
                eDe  <= modelActive();
                eX   <= modelActive() ? mHc : 0;
                eY   <= modelActive() ? mVc : 0;
                eHs  <= inWindow(mHc, mCfg[0] + mCfg[1], mCfg[2]) ? mHpol : ~mHpol;
                eVs  <= inWindow(mVc, mCfg[4] + mCfg[5], mCfg[6]) ? mVpol : ~mVpol;
                eSof <= (mHc == 0) && (mVc == 0);
                eEol <= (mHc == mCfg[0] - 1) && (mVc < mCfg[4]);
                eRgb <= modelActive() ? barColour(mHc) : 0;
                mHc  <= nextPos() % lineLen();
                mVc  <= nextPos() / lineLen();
                if (mBusy && framePos() == lineLen() * frameLines() - 1) begin
                    for (int i = 0; i < 8; i++) mCfg[i] <= sCfg[i];
                    mHpol <= sHpol;
                    mVpol <= sVpol;
                    mBusy <= 1'b0;
                end
            end
            if (cfgLoad && capOk()) begin
                sCfg[0] <= fixZero(int'(cfgHa));  sCfg[1] <= fixZero(int'(cfgHfp));
                sCfg[2] <= fixZero(int'(cfgHs));  sCfg[3] <= fixZero(int'(cfgHbp));
                sCfg[4] <= fixZero(int'(cfgVa));  sCfg[5] <= fixZero(int'(cfgVfp));
                sCfg[6] <= fixZero(int'(cfgVs));  sCfg[7] <= fixZero(int'(cfgVbp));
                sHpol <= cfgHpol;
                sVpol <= cfgVpol;
                mBusy <= 1'b1;
            end
        end
    end

    // Compare every output of the small-timing instance with the model
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("busy", int'(busyM), int'(mBusy));
            checkOutput("hs",   int'(hsM),   int'(eHs));
            checkOutput("vs",   int'(vsM),   int'(eVs));
            checkOutput("de",   int'(deM),   int'(eDe));
            checkOutput("x",    int'(xM),    eX);
            checkOutput("y",    int'(yM),    eY);
            checkOutput("sof",  int'(sofM),  int'(eSof));
            checkOutput("eol",  int'(eolM),  int'(eEol));
`ifdef VTG_PATTERN_EN
            checkOutput("rgb",  int'(rgbM),  eRgb);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit hpol, input bit vpol);
        cfgHa = W'(ha);  cfgHfp = W'(hfp); cfgHs = W'(hsw); cfgHbp = W'(hbp);
        cfgVa = W'(va);  cfgVfp = W'(vfp); cfgVs = W'(vsw); cfgVbp = W'(vbp);
        cfgHpol = hpol;  cfgVpol = vpol;
        cfgLoad = 1'b1;
        @(negedge clk);
        cfgLoad = 1'b0;
    endtask

    task automatic waitSof();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sofM && n < 3000);
        if (!sofM) checkOutput("sofTimeout", 0, 1);
    endtask

    task automatic measureFrame(input bit pol, output int cycles, output int deCnt,
                                output int hsCnt, output int eolCnt, output int firstHs);
        cycles = 0; deCnt = 0; hsCnt = 0; eolCnt = 0; firstHs = -1;
        do begin
            deCnt  += int'(deM);
            eolCnt += int'(eolM);
            if (hsM == pol) begin
                hsCnt++;
                if (firstHs < 0) firstHs = cycles;
            end
            cycles++;
            @(negedge clk);
        end while (!sofM && cycles < 5000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc, deC, hsC, eolC, fHs;
        int deSum, hsLow, vsLow, eolCnt, eolIdx0, eolIdx1, xAtEol, firstHsLow, yAt800, sofCnt;

        rst = 1'b1; en = 1'b1; cfgLoad = 1'b0;
        cfgHa = '0; cfgHfp = '0; cfgHs = '0; cfgHbp = '0;
        cfgVa = '0; cfgVfp = '0; cfgVs = '0; cfgVbp = '0;
        cfgHpol = 1'b0; cfgVpol = 1'b0;
        repeat (3) @(negedge clk);
        checkOn = 1'b1;

        // Reset state of both instances
        checkOutput("rstHs",    int'(hsM),    1);
        checkOutput("rstVs",    int'(vsM),    1);
        checkOutput("rstDe",    int'(deM),    0);
        checkOutput("rstBusy",  int'(busyM),  0);
        checkOutput("rstDefHs", int'(hsDef),  1);
        checkOutput("rstDefDe", int'(deDef),  0);
        checkOutput("rstDefY",  int'(yDef),   0);
        rst = 1'b0;

        // Standard 640x480 timing: first three lines
        deSum = 0; hsLow = 0; vsLow = 0; eolCnt = 0; eolIdx0 = -1; eolIdx1 = -1;
        xAtEol = -1; firstHsLow = -1; yAt800 = -1; sofCnt = 0;
        for (int s = 0; s < 2400; s++) begin
            @(negedge clk);
            deSum  += int'(deDef);
            sofCnt += int'(sofDef);
            if (!hsDef) begin
                hsLow++;
                if (firstHsLow < 0) firstHsLow = s;
            end
            if (!vsDef) vsLow++;
            if (eolDef) begin
                eolCnt++;
                if (eolIdx0 < 0) begin
                    eolIdx0 = s;
                    xAtEol  = int'(xDef);
                end else if (eolIdx1 < 0) begin
                    eolIdx1 = s;
                end
            end
            if (s == 800) yAt800 = int'(yDef);
        end
        checkOutput("defDe3Lines",   deSum,      1920);
        checkOutput("defHsLow3",     hsLow,      288);
        checkOutput("defHsStart",    firstHsLow, 656);
        checkOutput("defVsLow",      vsLow,      0);
        checkOutput("defEolCount",   eolCnt,     3);
        checkOutput("defEolFirst",   eolIdx0,    639);
        checkOutput("defLinePeriod", eolIdx1 - eolIdx0, 800);
        checkOutput("defXAtEol",     xAtEol,     639);
        checkOutput("defYLine1",     yAt800,     1);
        checkOutput("defSofCount",   sofCnt,     1);

        // Mid-frame load of a small timing
        repeat (37) @(negedge clk);
        applyStimulus(8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        checkOutput("busyAfterLoad", int'(busyM), 1);
        waitSof();
        checkOutput("busyAfterApply", int'(busyM), 0);
        checkOutput("sofX", int'(xM), 0);
        checkOutput("sofY", int'(yM), 0);
        measureFrame(1'b1, cyc, deC, hsC, eolC, fHs);
        checkOutput("smallFrameLen", cyc,  98);
        checkOutput("smallDe",       deC,  32);
        checkOutput("smallHs",       hsC,  21);
        checkOutput("smallEol",      eolC, 4);
        checkOutput("smallHsStart",  fHs,  10);

        // Two loads in one frame: newest wins
        repeat (5) @(negedge clk);
        applyStimulus(8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        applyStimulus(10, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        checkOutput("busyDoubleLoad", int'(busyM), 1);
        waitSof();
        measureFrame(1'b1, cyc, deC, hsC, eolC, fHs);
        checkOutput("ha10FrameLen", cyc, 112);
        checkOutput("ha10De",       deC, 40);
        checkOutput("ha10HsStart",  fHs, 12);

        // Enable dropped for five cycles mid-line
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        waitSof();
        measureFrame(1'b1, cyc, deC, hsC, eolC, fHs);
        checkOutput("afterPauseLen", cyc, 112);

        // Zero sync width becomes one pixel
        repeat (4) @(negedge clk);
        applyStimulus(8, 2, 0, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        waitSof();
        measureFrame(1'b1, cyc, deC, hsC, eolC, fHs);
        checkOutput("hs0FrameLen", cyc, 84);
        checkOutput("hs0Width",    hsC, 7);
        checkOutput("hs0Start",    fHs, 10);

        // Overflowing total is rejected
        repeat (3) @(negedge clk);
        applyStimulus(4000, 100, 1, 1, 4, 1, 1, 1, 1'b0, 1'b0);
        checkOutput("busyOverflow", int'(busyM), 0);
        waitSof();
        measureFrame(1'b1, cyc, deC, hsC, eolC, fHs);
        checkOutput("overflowLen", cyc, 84);
        checkOutput("overflowHs",  hsC, 7);

        // Randomised enable and configuration traffic
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            cfgLoad = ($urandom_range(0, 39) == 0);
            cfgHa   = W'($urandom_range(0, 12));
            cfgHfp  = W'($urandom_range(0, 4));
            cfgHs   = W'($urandom_range(0, 4));
            cfgHbp  = W'($urandom_range(0, 4));
            cfgVa   = W'($urandom_range(0, 6));
            cfgVfp  = W'($urandom_range(0, 3));
            cfgVs   = W'($urandom_range(0, 3));
            cfgVbp  = W'($urandom_range(0, 3));
            cfgHpol = 1'($urandom_range(0, 1));
            cfgVpol = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) cfgHa = W'(4095);
            @(negedge clk);
        end
        cfgLoad = 1'b0;
        en = 1'b1;
        repeat (7) @(negedge clk);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstHs",   int'(hsM),   1);
        checkOutput("asyncRstVs",   int'(vsM),   1);
        checkOutput("asyncRstDe",   int'(deM),   0);
        checkOutput("asyncRstX",    int'(xM),    0);
        checkOutput("asyncRstY",    int'(yM),    0);
        checkOutput("asyncRstSof",  int'(sofM),  0);
        checkOutput("asyncRstEol",  int'(eolM),  0);
        checkOutput("asyncRstBusy", int'(busyM), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);

        checkOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
